// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide front end: op codes, FSM states, widths.
package mdu_pkg;
  localparam int XLEN = 32;
  localparam int CNTW = 5;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_START = 2'd1,
    DIV_WAIT  = 2'd2,
    MUL_RUN   = 2'd3
  } state_e;
endpackage

// File: rtl/seq_mul.sv
// Radix-2 shift-add multiplier on operand magnitudes; sign fixed up on the final step.
// done marks the cycle whose edge performs the last iteration, with product already valid.
module seq_mul #(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              is_signed,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   mcand_reg;
  logic              neg_reg;
  logic [CNTW-1:0]   cnt_reg;

  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    a_mag    = (is_signed && a[XLEN-1]) ? -a : a;
    b_mag    = (is_signed && b[XLEN-1]) ? -b : b;
    sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    acc_step = {sum, acc_reg[XLEN-1:1]};
    done     = busy && (cnt_reg == {CNTW{1'b1}});
    product  = neg_reg ? -acc_step : acc_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      neg_reg   <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
    end else if (load) begin
      // Multiplier magnitude sits in the low half and is consumed LSB-first.
      acc_reg   <= {{XLEN{1'b0}}, b_mag};
      mcand_reg <= a_mag;
      neg_reg   <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
      cnt_reg   <= '0;
      busy      <= 1'b1;
    end else if (busy) begin
      acc_reg <= acc_step;
      cnt_reg <= cnt_reg + CNTW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/mdu_hilo_ctrl.sv
// MDU front end: owns HI/LO, drives the external iterative divider and the local
// shift-add multiplier, and holds mdu_busy while either is in flight.
module mdu_hilo_ctrl #(
  parameter int XLEN = mdu_pkg::XLEN,
  parameter int CNTW = mdu_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            mdu_busy,
  output logic            done,
  output logic            div_start,
  output logic            div_signed,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_busy,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r
);
  import mdu_pkg::*;

  state_e state_reg, state_next;
  logic accept_div, mul_load, cap_div, cap_mul, wr_hi, wr_lo;
  logic mul_busy, mul_done;
  logic [2*XLEN-1:0] mul_product;

  seq_mul #(.XLEN(XLEN), .CNTW(CNTW)) u_seq_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .is_signed (op == OP_MULT),
    .a         (rs_data),
    .b         (rt_data),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (mul_product)
  );

  always_comb begin
    state_next = state_reg;
    accept_div = 1'b0;
    mul_load   = 1'b0;
    cap_div    = 1'b0;
    cap_mul    = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state_reg)
      IDLE: if (op_valid) begin
        case (op)
          OP_MULT, OP_MULTU: begin mul_load = 1'b1; state_next = MUL_RUN; end
          OP_DIV, OP_DIVU:   begin accept_div = 1'b1; state_next = DIV_START; end
          OP_MTHI:           wr_hi = 1'b1;
          OP_MTLO:           wr_lo = 1'b1;
          default:           ;
        endcase
      end
      DIV_START: state_next = DIV_WAIT;
      // The divider raises busy on the edge that samples start, so a low here is final.
      DIV_WAIT: if (!div_busy) begin cap_div = 1'b1; state_next = IDLE; end
      MUL_RUN: begin
        if (mul_done) begin cap_mul = 1'b1; state_next = IDLE; end
        else if (!mul_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hi           <= '0;
      lo           <= '0;
      mdu_busy     <= 1'b0;
      done         <= 1'b0;
      div_start    <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      state_reg <= state_next;
      mdu_busy  <= (state_next != IDLE);
      done      <= cap_div | cap_mul;
      div_start <= accept_div;
      // Operands stay frozen until capture: the divider sign-corrects q/r from div_signed.
      if (accept_div) begin
        div_dividend <= rs_data;
        div_divisor  <= rt_data;
        div_signed   <= (op == OP_DIV);
      end
      if (cap_div) begin
        hi <= div_r;
        lo <= div_q;
      end else if (cap_mul) begin
        {hi, lo} <= mul_product;
      end else begin
        if (wr_hi) hi <= rs_data;
        if (wr_lo) lo <= rs_data;
      end
    end
  end
endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Scoreboard bench for mdu_hilo_ctrl with a behavioural 32-cycle divider model.
module tb_mdu_hilo_ctrl;
  import mdu_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] rs_data = '0, rt_data = '0;
  logic [W-1:0] hi, lo, div_dividend, div_divisor, div_q, div_r;
  logic mdu_busy, done, div_start, div_signed;
  logic div_busy;

  mdu_hilo_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi(hi), .lo(lo),
    .mdu_busy(mdu_busy), .done(done), .div_start(div_start),
    .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_busy(div_busy),
    .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: busy for 32 cycles after sampling start; sign applied live from div_signed.
  logic [W-1:0] am, bm, mq_reg, mr_reg;
  logic qneg_reg, rneg_reg;
  int dcnt;
  assign am = (div_signed && div_dividend[W-1]) ? -div_dividend : div_dividend;
  assign bm = (div_signed && div_divisor[W-1])  ? -div_divisor  : div_divisor;
  assign div_q = (div_signed && qneg_reg) ? -mq_reg : mq_reg;
  assign div_r = (div_signed && rneg_reg) ? -mr_reg : mr_reg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0; dcnt <= 0; mq_reg <= '0; mr_reg <= '0;
      qneg_reg <= 1'b0; rneg_reg <= 1'b0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      dcnt     <= 31;
      mq_reg   <= (bm == 0) ? '1 : am / bm;
      mr_reg   <= (bm == 0) ? am : am % bm;
      qneg_reg <= div_dividend[W-1] ^ div_divisor[W-1];
      rneg_reg <= div_dividend[W-1];
    end else if (div_busy) begin
      if (dcnt == 0) div_busy <= 1'b0;
      else dcnt <= dcnt - 1;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [63:0] hilo;
    int          due;
    string       tag;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_hilo"}, {hi, lo}, mon_e.hilo);
        chk({mon_e.tag, "_edge"}, 64'(cyc), 64'(mon_e.due));
        $display("txn %s: hi=%h lo=%h cyc=%0d", mon_e.tag, hi, lo, cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Issue a MUL/DIV, push its expectation, check handshake and wait for completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp, input bit inject_mtlo);
    bit is_div;
    int n;
    is_div = (o == OP_DIV) || (o == OP_DIVU);
    sb.push_back('{exp, cyc + 1 + (is_div ? 34 : 32), tag});
    issue(o, a, b);
    chk({tag, "_busy"}, mdu_busy, 1);
    if (is_div) begin
      chk({tag, "_start"}, div_start, 1);
      chk({tag, "_dividend"}, div_dividend, a);
      chk({tag, "_divisor"}, div_divisor, b);
    end else begin
      chk({tag, "_nostart"}, div_start, 0);
    end
    for (n = 0; n < 60; n++) begin
      if (!mdu_busy) break;
      @(negedge clk);
      if (is_div && mdu_busy) begin
        chk({tag, "_start_once"}, div_start, 0);
        chk({tag, "_signed_hold"}, div_signed, (o == OP_DIV));
        chk({tag, "_dividend_hold"}, div_dividend, a);
      end
      if (inject_mtlo && n == 5) begin
        op_valid = 1'b1; op = OP_MTLO; rs_data = 32'hDEADBEEF;
      end
      if (inject_mtlo && n == 6) op_valid = 1'b0;
    end
    chk({tag, "_idle_timeout"}, mdu_busy, 0);
  endtask

  function automatic logic [63:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    logic signed [63:0] sa, sb2;
    if (sgn) begin
      sa = {{32{a[W-1]}}, a}; sb2 = {{32{b[W-1]}}, b};
      return sa * sb2;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] div_ref(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    int sa, sbv;
    if (sgn) begin
      sa = a; sbv = b;
      return {32'(sa % sbv), 32'(sa / sbv)};
    end
    return {a % b, a / b};
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    bit rs;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", div_start, 0);
    chk("rst_signed", div_signed, 0);
    chk("rst_operands", {div_dividend, div_divisor}, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(OP_MTHI, 32'h12345678, 32'h0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_no_done", done, 0);
    chk("mthi_no_busy", mdu_busy, 0);
    issue(OP_MTLO, 32'hCAFEF00D, 32'h0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    issue(3'd7, 32'h55555555, 32'h1);
    chk("undef_busy", mdu_busy, 0);
    chk("undef_hilo", {hi, lo}, 64'h12345678_CAFEF00D);

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("divu_mtlo_ignored", OP_DIVU, 32'd1000, 32'd33, {32'd10, 32'd30}, 1'b1);
    run_op("mult_m3_5", OP_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
    run_op("mult_m1_m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0);
    run_op("mult_minint", OP_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
    run_op("divu_by_zero", OP_DIVU, 32'd77, 32'd0, {32'd77, 32'hFFFFFFFF}, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'(i);
      run_op(rs ? "rand_mult" : "rand_multu", rs ? OP_MULT : OP_MULTU, ra, rb, mul_ref(ra, rb, rs), 1'b0);
      rb = 32'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op(rs ? "rand_div" : "rand_divu", rs ? OP_DIV : OP_DIVU, ra, rb, div_ref(ra, rb, rs), 1'b0);
    end

    // Reset ten cycles into DIV_WAIT; the pending result must never appear.
    sb.push_back('{64'h0, cyc + 35, "divu_killed"});
    issue(OP_DIVU, 32'd500, 32'd3);
    repeat (10) @(negedge clk);
    chk("kill_in_wait", div_busy, 1);
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    chk("kill_hilo", {hi, lo}, 0);
    chk("kill_busy", mdu_busy, 0);
    chk("kill_start", div_start, 0);
    chk("kill_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
